// File: rtl/chip8_mem_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem_seq_if
// Description : Command, register-file and memory bus for chip8_mem_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface chip8_mem_seq_if;
    logic        start;
    logic [1:0]  cmd;
    logic [3:0]  x;
    logic [11:0] i_addr;
    logic [7:0]  vx_val;
    logic        busy;
    logic        done;
    logic        i_upd;
    logic [11:0] i_next;
    logic [3:0]  reg_raddr;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output start, cmd, x, i_addr, vx_val, reg_rdata, mem_rdata,
        input  busy, done, i_upd, i_next, reg_raddr, reg_we, reg_waddr,
               reg_wdata, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        input  start, cmd, x, i_addr, vx_val, reg_rdata, mem_rdata,
        output busy, done, i_upd, i_next, reg_raddr, reg_we, reg_waddr,
               reg_wdata, mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/chip8_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : chip8_mem_seq
// Description : Sequencer for CHIP-8 Fx55 / Fx65 / Fx33 memory transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module chip8_mem_seq #(
    parameter int INC_I = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    chip8_mem_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_STORE = 3'd1,
        S_LOAD  = 3'd2,
        S_DRAIN = 3'd3,
        S_BCD   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] c_CMD_STORE = 2'b00;
    localparam logic [1:0] c_CMD_LOAD  = 2'b01;
    localparam logic [1:0] c_CMD_BCD   = 2'b10;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_k;
    logic [3:0]  w_k_next;
    logic [1:0]  r_cmd;
    logic [3:0]  r_x;
    logic [11:0] r_i;
    logic [7:0]  r_vx;
    logic        r_wb_valid;
    logic        w_wb_valid_next;
    logic [3:0]  r_wb_idx;

    logic [11:0] w_addr;
    logic [7:0]  w_bcd_hund;
    logic [7:0]  w_bcd_tens;
    logic [7:0]  w_bcd_ones;

    assign w_addr     = r_i + {8'd0, r_k};
    assign w_bcd_hund = r_vx / 8'd100;
    assign w_bcd_tens = (r_vx / 8'd10) % 8'd10;
    assign w_bcd_ones = r_vx % 8'd10;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_k     <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
        end
    end

    // Operands are captured only on acceptance so input changes mid-transfer are invisible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd      <= 2'd0;
            r_x        <= 4'd0;
            r_i        <= 12'd0;
            r_vx       <= 8'd0;
            r_wb_valid <= 1'b0;
            r_wb_idx   <= 4'd0;
        end else begin
            if (r_state == S_IDLE && bus.start) begin
                r_cmd <= bus.cmd;
                r_x   <= bus.x;
                r_i   <= bus.i_addr;
                r_vx  <= bus.vx_val;
            end
            r_wb_valid <= w_wb_valid_next;
            if (r_state == S_LOAD) begin
                r_wb_idx <= r_k;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_k_next        = r_k;
        w_wb_valid_next = 1'b0;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.i_upd       = 1'b0;
        bus.i_next      = 12'd0;
        bus.reg_raddr   = 4'd0;
        bus.reg_we      = 1'b0;
        bus.reg_waddr   = 4'd0;
        bus.reg_wdata   = 8'd0;
        bus.mem_we      = 1'b0;
        bus.mem_re      = 1'b0;
        bus.mem_addr    = 12'd0;
        bus.mem_wdata   = 8'd0;

        // Load write-back trails its read by one cycle, overlapping the next read.
        if (r_wb_valid) begin
            bus.reg_we    = 1'b1;
            bus.reg_waddr = r_wb_idx;
            bus.reg_wdata = bus.mem_rdata;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_k_next = 4'd0;
                    case (bus.cmd)
                        c_CMD_STORE: w_state_next = S_STORE;
                        c_CMD_LOAD:  w_state_next = S_LOAD;
                        c_CMD_BCD:   w_state_next = S_BCD;
                        default:     w_state_next = S_DONE;
                    endcase
                end
            end
            S_STORE: begin
                bus.busy      = 1'b1;
                bus.reg_raddr = r_k;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = w_addr;
                bus.mem_wdata = bus.reg_rdata;
                if (r_k == r_x) begin
                    w_state_next = S_DONE;
                end else begin
                    w_k_next = r_k + 4'd1;
                end
            end
            S_LOAD: begin
                bus.busy        = 1'b1;
                bus.mem_re      = 1'b1;
                bus.mem_addr    = w_addr;
                w_wb_valid_next = 1'b1;
                if (r_k == r_x) begin
                    w_state_next = S_DRAIN;
                end else begin
                    w_k_next = r_k + 4'd1;
                end
            end
            S_DRAIN: begin
                bus.busy     = 1'b1;
                w_state_next = S_DONE;
            end
            S_BCD: begin
                bus.busy     = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = w_addr;
                case (r_k)
                    4'd0:    bus.mem_wdata = w_bcd_hund;
                    4'd1:    bus.mem_wdata = w_bcd_tens;
                    default: bus.mem_wdata = w_bcd_ones;
                endcase
                if (r_k == 4'd2) begin
                    w_state_next = S_DONE;
                end else begin
                    w_k_next = r_k + 4'd1;
                end
            end
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                // Only store/load advance I; BCD and reserved share cmd[1]=1.
                if ((INC_I != 0) && !r_cmd[1]) begin
                    bus.i_upd  = 1'b1;
                    bus.i_next = r_i + {8'd0, r_x} + 12'd1;
                end
                w_k_next     = 4'd0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_chip8_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_chip8_mem_seq
// Description : Self-checking bench for chip8_mem_seq with memory/regfile model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chip8_mem_seq;

    localparam int INC_I = 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    chip8_mem_seq_if bus ();

    chip8_mem_seq #(.INC_I(INC_I)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mem [4096];
    logic [7:0] regs [16];

    assign bus.reg_rdata = regs[bus.reg_raddr];

    // Environment: reset restores known contents; otherwise honour DUT strobes.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'h5A;
            for (int i = 0; i < 16; i++) regs[i] <= 8'(8'hAB + i * 16);
        end else begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            if (bus.reg_we) regs[bus.reg_waddr] <= bus.reg_wdata;
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Operation currently expected of the DUT.
    logic        op_active = 1'b0;
    logic [1:0]  op_cmd = 2'd0;
    logic [3:0]  op_x = 4'd0;
    logic [11:0] op_i = 12'd0;
    logic [7:0]  op_vx = 8'd0;
    int          op_t0 = 0;

    int          done_cnt = 0;
    int          last_done_n = 0;
    logic [11:0] last_inext = 12'd0;

    int          n, lat;
    logic        e_busy, e_done, e_mwe, e_mre, e_rwe, e_iupd, e_store;
    logic [11:0] e_addr, e_inext;
    logic [7:0]  e_wdata, e_rwdata;
    logic [3:0]  e_waddr, e_raddr;

    always @(negedge clk) begin
        e_busy = 0; e_done = 0; e_mwe = 0; e_mre = 0; e_rwe = 0; e_iupd = 0; e_store = 0;
        e_addr = 0; e_inext = 0; e_wdata = 0; e_rwdata = 0; e_waddr = 0; e_raddr = 0;
        n = cyc - op_t0 + 1;
        case (op_cmd)
            2'b00:   lat = int'(op_x) + 2;
            2'b01:   lat = int'(op_x) + 3;
            2'b10:   lat = 4;
            default: lat = 1;
        endcase
        if (!reset && op_active && n >= 1 && n <= lat) begin
            e_busy = 1;
            if (n == lat) begin
                e_done = 1;
                if (INC_I != 0 && op_cmd < 2'b10) begin
                    e_iupd  = 1;
                    e_inext = 12'(int'(op_i) + int'(op_x) + 1);
                end
            end
            if (op_cmd == 2'b00 && n <= int'(op_x) + 1) begin
                e_mwe = 1; e_store = 1;
                e_addr  = 12'(int'(op_i) + n - 1);
                e_raddr = 4'(n - 1);
                e_wdata = regs[4'(n - 1)];
            end
            if (op_cmd == 2'b10 && n <= 3) begin
                e_mwe  = 1;
                e_addr = 12'(int'(op_i) + n - 1);
                if (n == 1)      e_wdata = op_vx / 8'd100;
                else if (n == 2) e_wdata = (op_vx / 8'd10) % 8'd10;
                else             e_wdata = op_vx % 8'd10;
            end
            if (op_cmd == 2'b01 && n <= int'(op_x) + 1) begin
                e_mre  = 1;
                e_addr = 12'(int'(op_i) + n - 1);
            end
            if (op_cmd == 2'b01 && n >= 2 && n <= int'(op_x) + 2) begin
                e_rwe    = 1;
                e_waddr  = 4'(n - 2);
                e_rwdata = mem[12'(int'(op_i) + n - 2)];
            end
        end
        chk("busy", 32'(bus.busy), 32'(e_busy));
        chk("done", 32'(bus.done), 32'(e_done));
        chk("mem_we", 32'(bus.mem_we), 32'(e_mwe));
        chk("mem_re", 32'(bus.mem_re), 32'(e_mre));
        chk("reg_we", 32'(bus.reg_we), 32'(e_rwe));
        chk("i_upd", 32'(bus.i_upd), 32'(e_iupd));
        if (e_mwe || e_mre) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
        if (e_mwe) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_wdata));
        if (e_store) chk("reg_raddr", 32'(bus.reg_raddr), 32'(e_raddr));
        if (e_rwe) begin
            chk("reg_waddr", 32'(bus.reg_waddr), 32'(e_waddr));
            chk("reg_wdata", 32'(bus.reg_wdata), 32'(e_rwdata));
        end
        if (e_iupd) chk("i_next", 32'(bus.i_next), 32'(e_inext));
        if (reset) begin
            chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
            chk("rst_reg_waddr", 32'(bus.reg_waddr), 32'd0);
            chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
            chk("rst_i_next", 32'(bus.i_next), 32'd0);
        end
        if (bus.done) begin
            done_cnt    <= done_cnt + 1;
            last_done_n <= n;
            last_inext  <= bus.i_next;
        end
    end

    // Called at posedge+1; the following rising edge accepts the command.
    task automatic issue(input logic [1:0] c, input logic [3:0] xx,
                         input logic [11:0] ia, input logic [7:0] vx);
        bus.cmd = c; bus.x = xx; bus.i_addr = ia; bus.vx_val = vx; bus.start = 1'b1;
        op_cmd = c; op_x = xx; op_i = ia; op_vx = vx; op_t0 = cyc + 1; op_active = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cmd = ~c; bus.x = ~xx; bus.i_addr = ~ia; bus.vx_val = ~vx;
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    int d0;

    initial begin
        bus.start = 1'b0; bus.cmd = 2'd0; bus.x = 4'd0; bus.i_addr = 12'd0; bus.vx_val = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // BCD of 0xFE at 0x300, issued on the first edge after reset release.
        d0 = done_cnt;
        issue(2'b10, 4'd0, 12'h300, 8'hFE);
        wait_cycles(5);
        chk("bcd_hund", 32'(mem[12'h300]), 32'h02);
        chk("bcd_tens", 32'(mem[12'h301]), 32'h05);
        chk("bcd_ones", 32'(mem[12'h302]), 32'h04);
        chk("bcd_latency", 32'(last_done_n), 32'd4);
        chk("bcd_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Single-register store.
        issue(2'b00, 4'd0, 12'h200, 8'h00);
        wait_cycles(3);
        chk("st0_data", 32'(mem[12'h200]), 32'hAB);
        chk("st0_latency", 32'(last_done_n), 32'd2);
        chk("st0_inext", 32'(last_inext), 32'h201);

        // Store x=5 with an ignored start pulse in the middle.
        d0 = done_cnt;
        issue(2'b00, 4'd5, 12'h7F0, 8'h00);
        wait_cycles(1);
        bus.start = 1'b1; bus.cmd = 2'b01; bus.x = 4'd3; bus.i_addr = 12'h123;
        wait_cycles(1);
        bus.start = 1'b0;
        wait_cycles(6);
        chk("st5_last", 32'(mem[12'h7F5]), 32'hFB);
        chk("st5_latency", 32'(last_done_n), 32'd7);
        chk("st5_inext", 32'(last_inext), 32'h7F6);
        chk("st5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // Full load with address wrap.
        issue(2'b01, 4'hF, 12'hFFE, 8'h00);
        wait_cycles(19);
        chk("ld_v0", 32'(regs[0]), 32'hA4);
        chk("ld_v2", 32'(regs[2]), 32'h5A);
        chk("ld_vf", 32'(regs[15]), 32'h57);
        chk("ld_latency", 32'(last_done_n), 32'd18);
        chk("ld_inext", 32'(last_inext), 32'h00E);

        // Reserved command.
        issue(2'b11, 4'd7, 12'h400, 8'h55);
        wait_cycles(2);
        chk("rsv_latency", 32'(last_done_n), 32'd1);

        // BCD wrapping across 0xFFF.
        issue(2'b10, 4'd0, 12'hFFF, 8'd9);
        wait_cycles(5);
        chk("bcdw_fff", 32'(mem[12'hFFF]), 32'h00);
        chk("bcdw_000", 32'(mem[12'h000]), 32'h00);
        chk("bcdw_001", 32'(mem[12'h001]), 32'h09);

        // Reset while loading index 5.
        d0 = done_cnt;
        issue(2'b01, 4'hF, 12'h100, 8'h00);
        wait_cycles(5);
        #2;
        reset = 1'b1;
        op_active = 1'b0;
        wait_cycles(2);
        reset = 1'b0;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        issue(2'b00, 4'd1, 12'h050, 8'h00);
        wait_cycles(4);
        chk("post_rst_done", 32'(done_cnt - d0), 32'd1);
        chk("post_rst_latency", 32'(last_done_n), 32'd3);
        chk("post_rst_v1", 32'(mem[12'h051]), 32'hBB);

        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
